// File: rtl/sd_spi_router_if.sv
// Bundles the router's signals toward the core, the HPS mount logic, the
// physical SD slot and the virtual cards. The router is the slave; the
// environment around it is the master.
interface sd_spi_router_if #(
   parameter int NUM_VSD = 2,
   parameter int SEL_W   = 3
);
   logic [NUM_VSD-1:0] img_mounted;
   logic [NUM_VSD-1:0] img_nz;
   logic               spi_cs_n;
   logic               spi_sck;
   logic               spi_mosi;
   logic               spi_miso;
   logic               phy_cs_n;
   logic               phy_sck;
   logic               phy_mosi;
   logic               phy_miso;
   logic [NUM_VSD-1:0] vsd_ss_n;
   logic [NUM_VSD-1:0] vsd_miso;
   logic [SEL_W-1:0]   sel;
   logic               reset_img;
   logic               act_phy;
   logic               act_vsd;

   modport master (
      output img_mounted, img_nz, spi_cs_n, spi_sck, spi_mosi, phy_miso, vsd_miso,
      input  spi_miso, phy_cs_n, phy_sck, phy_mosi, vsd_ss_n, sel, reset_img,
             act_phy, act_vsd
   );

   modport slave (
      input  img_mounted, img_nz, spi_cs_n, spi_sck, spi_mosi, phy_miso, vsd_miso,
      output spi_miso, phy_cs_n, phy_sck, phy_mosi, vsd_ss_n, sel, reset_img,
             act_phy, act_vsd
   );
endinterface

// File: rtl/sd_spi_router.sv
// Routes the core's SD SPI master to the physical slot or a virtual card.
// The target follows HPS mount strobes; a change requested while a
// transaction is open is held back until chip select is released. Every
// mount strobe also requests a fixed-width core reset, and a toggle monitor
// on the data lines drives the activity LEDs.
module sd_spi_router #(
   parameter int NUM_VSD     = 2,
   parameter int ACT_TIMEOUT = 1000000,
   parameter int RST_PULSE   = 10000000,
   parameter int SEL_W       = 3
) (
   input logic            clk_sys,
   input logic            reset_n,
   sd_spi_router_if.slave bus
);
   localparam int RST_W = $clog2(RST_PULSE + 1);
   localparam int ACT_W = $clog2(ACT_TIMEOUT + 1);
   localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_PULSE - 1);
   localparam logic [ACT_W-1:0] ACT_MAX  = ACT_W'(ACT_TIMEOUT);

   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   r_pend_sel;
   logic               r_pend_v;
   logic               r_reset_img;
   logic [RST_W-1:0]   r_rst_cnt;
   logic [ACT_W-1:0]   r_act_cnt;
   logic               r_act_phy;
   logic               r_act_vsd;
   logic               r_mosi_d;
   logic               r_miso_d;

   logic [SEL_W-1:0]   w_eff_sel;
   logic [SEL_W-1:0]   w_target;
   logic               w_strobe;
   logic               w_phy_cs_n;
   logic               w_miso;
   logic [NUM_VSD-1:0] w_vsd_ss_n;
   logic               w_toggle;

   assign w_strobe = |bus.img_mounted;

   // Mount decode: the lowest strobing channel decides the next target.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      w_eff_sel = r_pend_v ? r_pend_sel : r_sel;
      w_target  = w_eff_sel;
      // Walk downward so the lowest set index is the last one applied.
      for (int k = NUM_VSD - 1; k >= 0; k--) begin
         if (bus.img_mounted[k]) begin
            if (bus.img_nz[k])
               w_target = SEL_W'(k + 1);
            else if (w_eff_sel == SEL_W'(k + 1))
               w_target = '0;
            else
               w_target = w_eff_sel;
         end
      end
   end

   // Routing of selects and return data from the committed selection.
   always_comb begin
      w_phy_cs_n = (r_sel != '0) | bus.spi_cs_n;
      w_vsd_ss_n = '1;
      w_miso     = 1'b1;
      if (r_sel == '0)
         w_miso = bus.phy_miso;
      for (int k = 0; k < NUM_VSD; k++) begin
         w_vsd_ss_n[k] = (r_sel != SEL_W'(k + 1)) | bus.spi_cs_n;
         if (r_sel == SEL_W'(k + 1))
            w_miso = bus.vsd_miso[k];
      end
   end

   assign w_toggle     = (bus.spi_mosi != r_mosi_d) | (w_miso != r_miso_d);

   assign bus.phy_cs_n  = w_phy_cs_n;
   assign bus.phy_sck   = bus.spi_sck & ~w_phy_cs_n;
   assign bus.phy_mosi  = bus.spi_mosi & ~w_phy_cs_n;
   assign bus.vsd_ss_n  = w_vsd_ss_n;
   assign bus.spi_miso  = w_miso;
   assign bus.sel       = r_sel;
   assign bus.reset_img = r_reset_img;
   assign bus.act_phy   = r_act_phy;
   assign bus.act_vsd   = r_act_vsd;

   // Selection commit: immediate when the bus is idle, deferred while chip select is low.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_sel      <= '0;
         r_pend_v   <= 1'b0;
         r_pend_sel <= '0;
      end else if (w_strobe) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         if (bus.spi_cs_n) begin
            r_sel    <= w_target;
            r_pend_v <= 1'b0;
         end else begin
            r_pend_v   <= 1'b1;
            r_pend_sel <= w_target;
         end
      end else if (r_pend_v && bus.spi_cs_n) begin
         r_sel    <= r_pend_sel;
         r_pend_v <= 1'b0;
      end
   end

   // Core reset pulse: any strobe (re)loads the full width.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_reset_img <= 1'b0;
         r_rst_cnt   <= '0;
      end else if (w_strobe) begin
         r_reset_img <= 1'b1;
         r_rst_cnt   <= RST_LOAD;
      end else if (r_rst_cnt != '0) begin
         r_rst_cnt   <= r_rst_cnt - 1'b1;
      end else begin
         r_reset_img <= 1'b0;
      end
   end

   // Activity monitor: data toggles restart an idle counter that saturates at the timeout.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_mosi_d  <= 1'b0;
         r_miso_d  <= 1'b0;
         r_act_cnt <= ACT_MAX;
         r_act_phy <= 1'b0;
         r_act_vsd <= 1'b0;
      end else begin
         r_mosi_d  <= bus.spi_mosi;
         r_miso_d  <= w_miso;
         if (w_toggle)
            r_act_cnt <= '0;
         else if (r_act_cnt < ACT_MAX)
            r_act_cnt <= r_act_cnt + 1'b1;
         r_act_phy <= (r_act_cnt < ACT_MAX) & (r_sel == '0);
         r_act_vsd <= (r_act_cnt < ACT_MAX) & (r_sel != '0);
      end
   end
endmodule

// File: tb/tb_sd_spi_router.sv
// Directed bench for sd_spi_router: expected values are queued when the
// stimulus is applied and compared when the DUT response is sampled.
module tb_sd_spi_router;
   localparam int NUM_VSD     = 2;
   localparam int ACT_TIMEOUT = 8;
   localparam int RST_PULSE   = 16;
   localparam int SEL_W       = 3;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   logic clk_sys;
   logic reset_n;
   exp_t sb_q[$];
   int   n_checks;
   int   n_errors;

   sd_spi_router_if #(.NUM_VSD(NUM_VSD), .SEL_W(SEL_W)) bus ();

   sd_spi_router #(
      .NUM_VSD    (NUM_VSD),
      .ACT_TIMEOUT(ACT_TIMEOUT),
      .RST_PULSE  (RST_PULSE),
      .SEL_W      (SEL_W)
   ) dut (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // Safety net in case the sequence below stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_errors++;
         $error("FAIL scoreboard_empty: observed %0h expected nothing queued", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic strobe(input logic [NUM_VSD-1:0] m, input logic [NUM_VSD-1:0] nz);
      bus.img_mounted = m;
      bus.img_nz      = nz;
      step();
      bus.img_mounted = '0;
      bus.img_nz      = '0;
   endtask

   // Counts consecutive high samples of reset_img starting with the current one.
   task automatic measure_pulse(output int n);
      n = 0;
      for (int i = 0; i < 100 && bus.reset_img; i++) begin
         n++;
         step();
      end
   endtask

   task automatic wait_pulse_end();
      for (int i = 0; i < 100 && bus.reset_img; i++) step();
      push("pulse_end", 0);
      check(32'(bus.reset_img));
   endtask

   initial begin
      int n;
      int n_act_phy;
      int n_act_vsd;
      int n_bad;
      n_checks = 0;
      n_errors = 0;

      bus.img_mounted = '0;
      bus.img_nz      = '0;
      bus.spi_cs_n    = 1'b1;
      bus.spi_sck     = 1'b0;
      bus.spi_mosi    = 1'b0;
      bus.phy_miso    = 1'b0;
      bus.vsd_miso    = '0;
      reset_n         = 1'b0;

      // Reset state
      #1;
      push("rst_sel", 0);       check(32'(bus.sel));
      push("rst_reset_img", 0); check(32'(bus.reset_img));
      push("rst_act_phy", 0);   check(32'(bus.act_phy));
      push("rst_act_vsd", 0);   check(32'(bus.act_vsd));
      push("rst_phy_cs_n", 1);  check(32'(bus.phy_cs_n));
      step();
      step();
      reset_n = 1'b1;
      step();

      // Mount ch0 with the bus idle: immediate switch to virtual card 0
      push("t1_sel", 1);
      push("t1_reset_img", 1);
      strobe(2'b01, 2'b01);
      check(32'(bus.sel));
      check(32'(bus.reset_img));
      push("t1_vsd_ss_idle", 2'b11);  check(32'(bus.vsd_ss_n));
      bus.spi_cs_n = 1'b0;
      bus.spi_sck  = 1'b1;
      #1;
      push("t1_vsd_ss_active", 2'b10); check(32'(bus.vsd_ss_n));
      push("t1_phy_cs_n", 1);          check(32'(bus.phy_cs_n));
      push("t1_phy_sck", 0);           check(32'(bus.phy_sck));
      bus.vsd_miso = 2'b01;
      #1;
      push("t1_miso_vsd0", 1);         check(32'(bus.spi_miso));
      bus.vsd_miso = '0;
      bus.spi_cs_n = 1'b1;
      bus.spi_sck  = 1'b0;
      // Pulse already high for the current sample after the strobe edge
      push("t1_pulse_width", RST_PULSE);
      measure_pulse(n);
      check(32'(n));

      // Unmount ch0 returns to the physical slot
      push("t2_unmount_sel", 0);
      strobe(2'b01, 2'b00);
      check(32'(bus.sel));
      wait_pulse_end();

      // Mount ch1 while a physical transaction is open: deferred switch
      bus.spi_cs_n = 1'b0;
      step();
      push("t2_pending_sel", 0);
      strobe(2'b10, 2'b10);
      n_bad = 0;
      for (int i = 0; i < 20; i++) begin
         bus.spi_sck  = ~bus.spi_sck;
         bus.spi_mosi = ~bus.spi_mosi;
         #1;
         if (bus.sel != 0 || bus.phy_cs_n != 1'b0 || bus.phy_sck != bus.spi_sck ||
             bus.phy_mosi != bus.spi_mosi)
            n_bad++;
         step();
      end
      check(32'(bus.sel));
      push("t2_phy_traffic_bad", 0);  check(32'(n_bad));
      bus.spi_sck  = 1'b0;
      bus.spi_mosi = 1'b0;
      bus.spi_cs_n = 1'b1;
      #1;
      push("t2_sel_before_edge", 0);  check(32'(bus.sel));
      step();
      push("t2_sel_after_release", 2); check(32'(bus.sel));
      push("t2_phy_cs_n_after", 1);    check(32'(bus.phy_cs_n));
      wait_pulse_end();

      // Simultaneous strobes: lowest index wins, then unmount it
      push("t3_both_sel", 1);
      strobe(2'b11, 2'b11);
      check(32'(bus.sel));
      push("t3_unmount_sel", 0);
      strobe(2'b01, 2'b00);
      check(32'(bus.sel));
      wait_pulse_end();

      // Empty image on a non-selected channel keeps the selection but still pulses
      push("t4_mount_sel", 1);
      strobe(2'b01, 2'b01);
      check(32'(bus.sel));
      wait_pulse_end();
      push("t4_keep_sel", 1);
      push("t4_keep_pulse", RST_PULSE);
      strobe(2'b10, 2'b00);
      check(32'(bus.sel));
      measure_pulse(n);
      check(32'(n));

      // Activity: one MOSI toggle on the physical slot
      push("t5_back_phy", 0);
      strobe(2'b01, 2'b00);
      check(32'(bus.sel));
      wait_pulse_end();
      repeat (12) step();
      push("t5_idle_act_phy", 0);  check(32'(bus.act_phy));
      bus.spi_mosi = 1'b1;
      push("t5_act_phy_cycles", ACT_TIMEOUT);
      push("t5_act_vsd_cycles", 0);
      n_act_phy = 0;
      n_act_vsd = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.act_phy) n_act_phy++;
         if (bus.act_vsd) n_act_vsd++;
      end
      check(32'(n_act_phy));
      check(32'(n_act_vsd));
      push("t5_act_phy_low", 0);   check(32'(bus.act_phy));
      repeat (1000) step();
      push("t5_long_act_phy", 0);  check(32'(bus.act_phy));
      push("t5_act_cnt_hold", ACT_TIMEOUT); check(32'(dut.r_act_cnt));

      // Second strobe at cycle 10 of a pulse restarts the full width
      push("t6_pulse_total", 10 + RST_PULSE);
      strobe(2'b01, 2'b00);
      n = 0;
      if (bus.reset_img) n++;
      for (int i = 0; i < 9; i++) begin
         step();
         if (bus.reset_img) n++;
      end
      strobe(2'b01, 2'b00);
      for (int i = 0; i < 100 && bus.reset_img; i++) begin
         n++;
         step();
      end
      check(32'(n));

      // Asynchronous reset mid-pulse with a pending selection
      push("t7_sel_pre", 1);
      strobe(2'b01, 2'b01);
      check(32'(bus.sel));
      repeat (3) step();
      bus.spi_cs_n = 1'b0;
      strobe(2'b10, 2'b10);
      #2;
      reset_n = 1'b0;
      #1;
      push("t7_async_reset_img", 0); check(32'(bus.reset_img));
      push("t7_async_sel", 0);       check(32'(bus.sel));
      step();
      reset_n = 1'b1;
      bus.spi_cs_n = 1'b1;
      step();
      step();
      push("t7_pending_lost", 0);    check(32'(bus.sel));
      push("t7_no_pulse", 0);        check(32'(bus.reset_img));

      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
